// File: rtl/argmax_classifier_pkg.sv
// Shared CNN stage definitions.
// Holds the argmax controller state encoding.
package argmax_classifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } argmax_state_e;

endpackage

// File: rtl/argmax_controller.sv
// Argmax sequencing FSM.
// Drives counter, load, compare and done controls for the datapath.
module argmax_controller
    import argmax_classifier_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic scan_first_i,
    input  logic scan_last_i,
    output logic accept_o,
    output logic cnt_en_o,
    output logic load_first_o,
    output logic cmp_en_o,
    output logic finish_o,
    output logic done_o,
    output logic busy_o
);

    argmax_state_e state_q, state_d;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        accept_o     = 1'b0;
        cnt_en_o     = 1'b0;
        load_first_o = 1'b0;
        cmp_en_o     = 1'b0;
        finish_o     = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    state_d  = ST_FIRST;
                end
            end
            ST_FIRST: begin
                cnt_en_o = 1'b1;
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                cnt_en_o = 1'b1;
                if (scan_first_i) begin
                    load_first_o = 1'b1;
                end else begin
                    cmp_en_o = 1'b1;
                end
                if (scan_last_i) begin
                    finish_o = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax over the Dense output buffer.
// Scans IN_COUNT signed scores; ties resolve to the lowest index.
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int IN_COUNT  = 10,
    parameter int DATA_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         axisif_start,
    output logic                         axisif_done,
    output logic [$clog2(IN_COUNT)-1:0]  axisif_bufferIn_adr,
    input  logic [DATA_SIZE-1:0]         axisif_bufferIn_data,
    output logic [$clog2(IN_COUNT)-1:0]  class_idx,
    output logic [DATA_SIZE-1:0]         class_score,
    output logic                         class_valid,
    output logic                         busy
);

    localparam int AW = $clog2(IN_COUNT);
    localparam logic [AW-1:0] LAST = AW'(IN_COUNT - 1);

    logic accept, cnt_en, load_first, cmp_en, finish;
    logic take;

    logic [AW-1:0] adr_q, adr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] max_idx_q, max_idx_d;
    logic [AW-1:0] cls_idx_q, cls_idx_d;
    logic signed [DATA_SIZE-1:0] max_q, max_d;
    logic signed [DATA_SIZE-1:0] cls_score_q, cls_score_d;
    logic valid_q, valid_d;

    argmax_controller u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start_i      (axisif_start),
        .scan_first_i (cnt_q == '0),
        .scan_last_i  (cnt_q == LAST),
        .accept_o     (accept),
        .cnt_en_o     (cnt_en),
        .load_first_o (load_first),
        .cmp_en_o     (cmp_en),
        .finish_o     (finish),
        .done_o       (axisif_done),
        .busy_o       (busy)
    );

    // Address, scan index, running max and result next-state.
    always_comb begin
        adr_d = '0;
        if (cnt_en) begin
            adr_d = (adr_q == LAST) ? adr_q : adr_q + 1'b1;
        end
        cnt_d = '0;
        if ((load_first || cmp_en) && !finish) begin
            cnt_d = cnt_q + 1'b1;
        end
        // cnt_q names the score arriving this cycle
        take = load_first ||
               (cmp_en && ($signed(axisif_bufferIn_data) > max_q));
        max_d     = take ? $signed(axisif_bufferIn_data) : max_q;
        max_idx_d = take ? cnt_q : max_idx_q;
        cls_idx_d   = cls_idx_q;
        cls_score_d = cls_score_q;
        if (finish) begin
            cls_idx_d   = max_idx_d;
            cls_score_d = max_d;
        end
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (finish) begin
            valid_d = 1'b1;
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q       <= '0;
            cnt_q       <= '0;
            max_idx_q   <= '0;
            max_q       <= '0;
            cls_idx_q   <= '0;
            cls_score_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            adr_q       <= adr_d;
            cnt_q       <= cnt_d;
            max_idx_q   <= max_idx_d;
            max_q       <= max_d;
            cls_idx_q   <= cls_idx_d;
            cls_score_q <= cls_score_d;
            valid_q     <= valid_d;
        end
    end

    assign axisif_bufferIn_adr = adr_q;
    assign class_idx           = cls_idx_q;
    assign class_score         = cls_score_q;
    assign class_valid         = valid_q;

endmodule
